// File: rtl/regfile_dump_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_dump_ctrl
// Streams the whole register file, big-endian, one byte at a time to the
// debug UART transmit path. While a dump runs, o_busy also freezes the
// pipeline so the register contents stay put.
//
// Ports
//   clk           system clock, rising edge
//   i_rst_n       synchronous active-low reset
//   i_start       dump request (honoured only when idle)
//   i_abort       stop at the next byte boundary (or at once while loading)
//   o_rd_addr     register-file read address (async read port)
//   i_rd_data     register-file read data for o_rd_addr
//   o_tx_data     byte to transmit
//   o_tx_valid    o_tx_data is valid
//   i_tx_ready    consumer accepts the byte
//   o_busy        dump in progress / pipeline freeze request
//   o_done        one-cycle pulse after a complete dump
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for i_start
// LOAD    | capture register r_index into the shift register
// SEND    | present MS byte, shift on each accepted byte
// DONE    | one-cycle completion pulse
// -----------------------------------------------------------------------------
module regfile_dump_ctrl #(
   parameter int NB_DATA = 32,
   parameter int NB_ADDR = 5,
   parameter int NB_BYTE = 8
) (
   input  logic               clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic               i_abort,
   output logic [NB_ADDR-1:0] o_rd_addr,
   input  logic [NB_DATA-1:0] i_rd_data,
   output logic [NB_BYTE-1:0] o_tx_data,
   output logic               o_tx_valid,
   input  logic               i_tx_ready,
   output logic               o_busy,
   output logic               o_done
);

   localparam int NB_BYTES = NB_DATA / NB_BYTE;
   localparam int NB_BCNT  = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
   localparam logic [NB_BCNT-1:0] BCNT_LAST = NB_BCNT'(NB_BYTES - 1);
   localparam logic [NB_ADDR-1:0] IDX_LAST  = '1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_SEND = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [NB_ADDR-1:0] r_index;
   logic [NB_ADDR-1:0] w_index_nxt;
   logic [NB_DATA-1:0] r_shift;
   logic [NB_DATA-1:0] w_shift_nxt;
   logic [NB_BCNT-1:0] r_bcnt;
   logic [NB_BCNT-1:0] w_bcnt_nxt;
   logic               r_abort;
   logic               w_abort_nxt;
   logic               w_abort_any;
   logic               w_xfer;

   always_ff @(posedge clk) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_index <= '0;
         r_shift <= '0;
         r_bcnt  <= '0;
         r_abort <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_index <= w_index_nxt;
         r_shift <= w_shift_nxt;
         r_bcnt  <= w_bcnt_nxt;
         r_abort <= w_abort_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_index_nxt = r_index;
      w_shift_nxt = r_shift;
      w_bcnt_nxt  = r_bcnt;
      w_abort_nxt = r_abort;
      o_tx_valid  = 1'b0;
      o_busy      = 1'b0;
      o_done      = 1'b0;
      w_xfer      = 1'b0;
      // a same-cycle abort counts as well as one latched earlier
      w_abort_any = i_abort | r_abort;

      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_index_nxt = '0;
               w_state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            o_busy     = 1'b1;
            w_bcnt_nxt = '0;
            if (w_abort_any) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_shift_nxt = i_rd_data;
               w_state_nxt = ST_SEND;
            end
         end
         ST_SEND: begin
            o_busy     = 1'b1;
            o_tx_valid = 1'b1;
            w_xfer     = i_tx_ready;
            if (w_xfer) begin
               w_shift_nxt = r_shift << NB_BYTE;
               w_bcnt_nxt  = r_bcnt + 1'b1;
               if (w_abort_any) begin
                  w_state_nxt = ST_IDLE;
               end else if (r_bcnt == BCNT_LAST) begin
                  // last register: no index increment, so the index never wraps
                  if (r_index == IDX_LAST) begin
                     w_state_nxt = ST_DONE;
                  end else begin
                     w_index_nxt = r_index + 1'b1;
                     w_state_nxt = ST_LOAD;
                  end
               end
            end
         end
         ST_DONE: begin
            o_busy      = 1'b1;
            o_done      = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      if (r_state != ST_IDLE) begin
         w_abort_nxt = r_abort | i_abort;
      end
      if (w_state_nxt == ST_IDLE) begin
         w_abort_nxt = 1'b0;
      end
   end

   assign o_rd_addr = r_index;
   assign o_tx_data = r_shift[NB_DATA-1 -: NB_BYTE];

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// -----------------------------------------------------------------------------
// tb_regfile_dump_ctrl
// Directed bench for regfile_dump_ctrl. Inputs change on the falling edge;
// outputs are sampled 1 ns later, so a byte is counted as transferred when
// valid and ready are both seen high in that cycle.
// -----------------------------------------------------------------------------
module tb_regfile_dump_ctrl;

   logic        clk = 1'b0;
   logic        i_rst_n;
   logic        i_start;
   logic        i_abort;
   logic [4:0]  o_rd_addr;
   logic [31:0] i_rd_data;
   logic [7:0]  o_tx_data;
   logic        o_tx_valid;
   logic        i_tx_ready;
   logic        o_busy;
   logic        o_done;

   logic [31:0] mem [32];

   int          n_chk = 0;
   int          n_err = 0;
   int          cyc;
   logic [7:0]  byte_q [$];
   int          done_cnt;
   int          done_cyc;
   int          busy_cnt;
   int          first_busy;
   int          last_busy;
   int          stall_cnt;
   int          hold_viol;
   logic        pend_hold;
   logic [7:0]  held_data;

   always #5 clk = ~clk;

   assign i_rd_data = mem[o_rd_addr];

   regfile_dump_ctrl #(
      .NB_DATA(32),
      .NB_ADDR(5),
      .NB_BYTE(8)
   ) u_dut (
      .clk        (clk),
      .i_rst_n    (i_rst_n),
      .i_start    (i_start),
      .i_abort    (i_abort),
      .o_rd_addr  (o_rd_addr),
      .i_rd_data  (i_rd_data),
      .o_tx_data  (o_tx_data),
      .o_tx_valid (o_tx_valid),
      .i_tx_ready (i_tx_ready),
      .o_busy     (o_busy),
      .o_done     (o_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      byte_q.delete();
      done_cnt   = 0;
      done_cyc   = -1;
      busy_cnt   = 0;
      first_busy = -1;
      last_busy  = -1;
      stall_cnt  = 0;
      hold_viol  = 0;
      pend_hold  = 1'b0;
      held_data  = 8'h00;
   endtask

   // Called just after the inputs of cycle 'cyc' were driven at the falling edge.
   task automatic tick();
      #1;
      if (o_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (o_busy) begin
         busy_cnt++;
         if (first_busy < 0) first_busy = cyc;
         last_busy = cyc;
      end
      if (o_tx_valid) begin
         if (pend_hold && (o_tx_data != held_data)) hold_viol++;
         if (i_tx_ready) begin
            byte_q.push_back(o_tx_data);
            pend_hold = 1'b0;
         end else begin
            stall_cnt++;
            pend_hold = 1'b1;
            held_data = o_tx_data;
         end
      end else if (pend_hold) begin
         hold_viol++;
         pend_hold = 1'b0;
      end
      @(negedge clk);
      cyc++;
   endtask

   // Pulse i_start for the edge that ends cycle 0; returns at start of cycle 1.
   task automatic start();
      clr();
      i_start = 1'b1;
      cyc     = 0;
      @(negedge clk);
      i_start = 1'b0;
      cyc     = 1;
   endtask

   task automatic check_seq(input string tag, input int n_exp);
      int errs;
      logic [31:0] word;
      logic [7:0]  exp_b;
      errs = 0;
      chk({tag, "_nbytes"}, 32'(byte_q.size()), 32'(n_exp));
      for (int k = 0; k < n_exp && k < byte_q.size(); k++) begin
         word  = 32'hA000_0000 + 32'(k / 4);
         exp_b = 8'((word >> (8 * (3 - (k % 4)))) & 32'hFF);
         if (byte_q[k] != exp_b) errs++;
      end
      chk({tag, "_bytes"}, 32'(errs), 32'd0);
   endtask

   task automatic full_run(input string tag);
      start();
      while (cyc <= 165) begin
         i_tx_ready = 1'b1;
         if (cyc == 1) begin
            #1;
            chk({tag, "_addr_c1"}, 32'(o_rd_addr), 32'd0);
            chk({tag, "_busy_c1"}, 32'(o_busy), 32'd1);
         end
         tick();
      end
      check_seq(tag, 128);
      chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
      chk({tag, "_done_cyc"}, 32'(done_cyc), 32'd161);
      chk({tag, "_busy_cnt"}, 32'(busy_cnt), 32'd161);
      chk({tag, "_busy_first"}, 32'(first_busy), 32'd1);
      chk({tag, "_busy_last"}, 32'(last_busy), 32'd161);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + 32'(i);
      i_rst_n    = 1'b0;
      i_start    = 1'b0;
      i_abort    = 1'b0;
      i_tx_ready = 1'b0;
      clr();
      repeat (3) @(negedge clk);
      #1;
      chk("rst_addr",  32'(o_rd_addr),  32'd0);
      chk("rst_data",  32'(o_tx_data),  32'd0);
      chk("rst_valid", 32'(o_tx_valid), 32'd0);
      chk("rst_busy",  32'(o_busy),     32'd0);
      chk("rst_done",  32'(o_done),     32'd0);
      @(negedge clk);
      i_rst_n = 1'b1;
      @(negedge clk);

      // full dump, always ready
      full_run("full");

      // random backpressure
      start();
      while (cyc < 2000 && (done_cyc < 0 || cyc <= done_cyc + 3)) begin
         i_tx_ready = 1'($urandom_range(0, 1));
         tick();
      end
      i_tx_ready = 1'b1;
      check_seq("bp", 128);
      chk("bp_done_cnt", 32'(done_cnt), 32'd1);
      chk("bp_done_cyc", 32'(done_cyc), 32'(161 + stall_cnt));
      chk("bp_hold", 32'(hold_viol), 32'd0);
      chk("bp_some_stalls", 32'(stall_cnt > 0), 32'd1);

      // second start during register 3 is ignored
      start();
      while (cyc <= 165) begin
         i_tx_ready = 1'b1;
         i_start    = (cyc == 18);
         tick();
      end
      i_start = 1'b0;
      check_seq("restart", 128);
      chk("restart_done_cnt", 32'(done_cnt), 32'd1);
      chk("restart_done_cyc", 32'(done_cyc), 32'd161);

      // abort pulse during byte 2 of register 5, consumer stalls 3 cycles
      start();
      while (cyc <= 40) begin
         i_tx_ready = !(cyc >= 29 && cyc <= 31);
         i_abort    = (cyc == 29);
         if (cyc == 33) begin
            #1;
            chk("abort_busy_c33",  32'(o_busy),     32'd0);
            chk("abort_valid_c33", 32'(o_tx_valid), 32'd0);
         end
         tick();
      end
      i_abort    = 1'b0;
      i_tx_ready = 1'b1;
      check_seq("abort", 23);
      chk("abort_done_cnt", 32'(done_cnt), 32'd0);
      chk("abort_hold", 32'(hold_viol), 32'd0);
      chk("abort_last_busy", 32'(last_busy), 32'd32);

      // abort in LOAD of register 0
      start();
      while (cyc <= 8) begin
         i_tx_ready = 1'b1;
         i_abort    = (cyc == 1);
         if (cyc == 2) begin
            #1;
            chk("ld_abort_busy_c2", 32'(o_busy), 32'd0);
         end
         tick();
      end
      i_abort = 1'b0;
      chk("ld_abort_nbytes", 32'(byte_q.size()), 32'd0);
      chk("ld_abort_done", 32'(done_cnt), 32'd0);

      // reset while a byte of register 10 is pending
      start();
      while (cyc < 53) begin
         i_tx_ready = 1'b1;
         tick();
      end
      i_tx_ready = 1'b0;
      i_rst_n    = 1'b0;
      #1;
      chk("rst_mid_valid", 32'(o_tx_valid), 32'd1);
      chk("rst_mid_addr", 32'(o_rd_addr), 32'd10);
      @(negedge clk);
      i_rst_n = 1'b1;
      #1;
      chk("rst_mid_o_addr",  32'(o_rd_addr),  32'd0);
      chk("rst_mid_o_data",  32'(o_tx_data),  32'd0);
      chk("rst_mid_o_valid", 32'(o_tx_valid), 32'd0);
      chk("rst_mid_o_busy",  32'(o_busy),     32'd0);
      chk("rst_mid_o_done",  32'(o_done),     32'd0);
      @(negedge clk);
      full_run("after_rst");

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
